// File: rtl/sysid_checker_pkg.sv
// Shared types and constants for the system ID startup checker.
package sysid_checker_pkg;

  typedef enum logic [2:0] {
    ST_BOOT,
    ST_REQ_ID,
    ST_WAIT_ID,
    ST_REQ_TS,
    ST_WAIT_TS,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_REQ,
    RD_WAIT
  } rd_phase_t;

  localparam int unsigned ID_OFS = 0;
  localparam int unsigned TS_OFS = 4;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    while ((64'd1 << res) < 64'(value)) res = res + 1;
    return res;
  endfunction

endpackage

// File: rtl/avm_single_read.sv
// Single outstanding Avalon-MM read: request, wait for data, per-transaction timeout.
module avm_single_read
  import sysid_checker_pkg::*;
#(
  parameter int unsigned        ADDR_W         = 32,
  parameter logic [ADDR_W-1:0]  RESET_ADDR     = '0,
  parameter int unsigned        TIMEOUT_CYCLES = 1024
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              go,
  input  logic [ADDR_W-1:0] addr,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  input  logic              avm_waitrequest,
  input  logic              avm_readdatavalid,
  input  logic [31:0]       avm_readdata,
  output logic              accept_c,
  output logic              valid_c,
  output logic [31:0]       data_c,
  output logic              timeout_c
);

  localparam int unsigned        CNT_W    = clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  rd_phase_t         phase_q, phase_d;
  logic              read_d;
  logic [ADDR_W-1:0] addr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      phase_q     <= RD_IDLE;
      avm_read    <= 1'b0;
      avm_address <= RESET_ADDR;
      cnt_q       <= '0;
    end else begin
      phase_q     <= phase_d;
      avm_read    <= read_d;
      avm_address <= addr_d;
      cnt_q       <= cnt_d;
    end
  end

  // Data landing in the accept cycle counts, so the wait phase can be skipped.
  always_comb begin
    phase_d   = phase_q;
    read_d    = avm_read;
    addr_d    = avm_address;
    cnt_d     = cnt_q;
    accept_c  = (phase_q == RD_REQ) && !avm_waitrequest;
    valid_c   = avm_readdatavalid && ((phase_q == RD_WAIT) || accept_c);
    data_c    = avm_readdata;
    timeout_c = (phase_q != RD_IDLE) && !valid_c && (cnt_q == CNT_LAST);

    if ((phase_q != RD_IDLE) && (cnt_q != CNT_LAST)) cnt_d = cnt_q + CNT_W'(1);

    case (phase_q)
      RD_REQ: begin
        if (accept_c) begin
          read_d  = 1'b0;
          phase_d = valid_c ? RD_IDLE : RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (valid_c) phase_d = RD_IDLE;
      end
      default: ;
    endcase

    if (timeout_c) begin
      phase_d = RD_IDLE;
      read_d  = 1'b0;
    end

    if (go) begin
      phase_d = RD_REQ;
      read_d  = 1'b1;
      addr_d  = addr;
      cnt_d   = '0;
    end
  end

endmodule

// File: rtl/sysid_checker.sv
// Reads and verifies the system ID / timestamp words after reset or on start.
module sysid_checker
  import sysid_checker_pkg::*;
#(
  parameter int unsigned       ADDR_W         = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR      = '0,
  parameter logic [31:0]       EXPECTED_ID    = 32'h0000_0000,
  parameter logic [31:0]       EXPECTED_TS    = 32'd1358911882,
  parameter bit                CHECK_TS       = 1'b1,
  parameter int unsigned       TIMEOUT_CYCLES = 1024,
  parameter int unsigned       MAX_RETRIES    = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  input  logic              avm_waitrequest,
  input  logic              avm_readdatavalid,
  input  logic [31:0]       avm_readdata,
  output logic              busy,
  output logic              done,
  output logic              id_ok,
  output logic              ts_ok,
  output logic              pass,
  output logic              timeout_err,
  output logic [31:0]       captured_id,
  output logic [31:0]       captured_ts
);

  localparam int unsigned       RETRY_W = clog2(MAX_RETRIES + 1) + 1;
  localparam logic [ADDR_W-1:0] ID_ADDR = BASE_ADDR + ADDR_W'(ID_OFS);
  localparam logic [ADDR_W-1:0] TS_ADDR = BASE_ADDR + ADDR_W'(TS_OFS);

  state_t             state_q, state_d;
  logic [RETRY_W-1:0] retries_q, retries_d;
  logic               busy_d, done_d, id_ok_d, ts_ok_d, pass_d, timeout_err_d;
  logic [31:0]        captured_id_d, captured_ts_d;
  logic               go_c, accept_c, valid_c, timeout_c;
  logic [ADDR_W-1:0]  addr_c;
  logic [31:0]        data_c;

  avm_single_read #(
    .ADDR_W         (ADDR_W),
    .RESET_ADDR     (BASE_ADDR),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_rd (
    .clock             (clock),
    .reset_n           (reset_n),
    .go                (go_c),
    .addr              (addr_c),
    .avm_address       (avm_address),
    .avm_read          (avm_read),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdatavalid (avm_readdatavalid),
    .avm_readdata      (avm_readdata),
    .accept_c          (accept_c),
    .valid_c           (valid_c),
    .data_c            (data_c),
    .timeout_c         (timeout_c)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_BOOT;
      retries_q   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      id_ok       <= 1'b0;
      ts_ok       <= 1'b0;
      pass        <= 1'b0;
      timeout_err <= 1'b0;
      captured_id <= '0;
      captured_ts <= '0;
    end else begin
      state_q     <= state_d;
      retries_q   <= retries_d;
      busy        <= busy_d;
      done        <= done_d;
      id_ok       <= id_ok_d;
      ts_ok       <= ts_ok_d;
      pass        <= pass_d;
      timeout_err <= timeout_err_d;
      captured_id <= captured_id_d;
      captured_ts <= captured_ts_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    retries_d     = retries_q;
    done_d        = done;
    id_ok_d       = id_ok;
    ts_ok_d       = ts_ok;
    timeout_err_d = timeout_err;
    captured_id_d = captured_id;
    captured_ts_d = captured_ts;
    go_c          = 1'b0;
    addr_c        = ID_ADDR;

    case (state_q)
      ST_BOOT: begin
        go_c      = 1'b1;
        retries_d = '0;
        state_d   = ST_REQ_ID;
      end
      ST_REQ_ID, ST_WAIT_ID: begin
        if (valid_c) begin
          captured_id_d = data_c;
          id_ok_d       = (data_c == EXPECTED_ID);
          go_c          = 1'b1;
          addr_c        = TS_ADDR;
          state_d       = ST_REQ_TS;
        end else if ((state_q == ST_REQ_ID) && accept_c) begin
          state_d = ST_WAIT_ID;
        end
      end
      ST_REQ_TS, ST_WAIT_TS: begin
        if (valid_c) begin
          captured_ts_d = data_c;
          ts_ok_d       = (data_c == EXPECTED_TS);
          done_d        = 1'b1;
          state_d       = ST_DONE;
        end else if ((state_q == ST_REQ_TS) && accept_c) begin
          state_d = ST_WAIT_TS;
        end
      end
      ST_DONE: begin
        if (start) begin
          done_d        = 1'b0;
          id_ok_d       = 1'b0;
          ts_ok_d       = 1'b0;
          timeout_err_d = 1'b0;
          retries_d     = '0;
          go_c          = 1'b1;
          state_d       = ST_REQ_ID;
        end
      end
      default: state_d = ST_BOOT;
    endcase

    // A timeout restarts the whole ID+TS sequence until retries run out.
    if (timeout_c && (state_q != ST_DONE) && (state_q != ST_BOOT)) begin
      if (retries_q < RETRY_W'(MAX_RETRIES)) begin
        retries_d = retries_q + RETRY_W'(1);
        go_c      = 1'b1;
        addr_c    = ID_ADDR;
        state_d   = ST_REQ_ID;
      end else begin
        timeout_err_d = 1'b1;
        done_d        = 1'b1;
        id_ok_d       = 1'b0;
        ts_ok_d       = 1'b0;
        state_d       = ST_DONE;
      end
    end

    busy_d = (state_d != ST_DONE);
    pass_d = done_d && id_ok_d && (ts_ok_d || !CHECK_TS) && !timeout_err_d;
  end

endmodule

// File: tb/tb_sysid_checker.sv
// Directed bench for sysid_checker with a small Avalon-MM slave model.
module tb_sysid_checker;

  localparam logic [31:0] EXP_TS = 32'd1358911882;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] avm_address, avm_address_b;
  logic        avm_read, avm_read_b;
  logic        waitreq, rdv;
  logic [31:0] rdata;
  logic        busy, done, id_ok, ts_ok, pass, timeout_err;
  logic [31:0] captured_id, captured_ts;
  logic        busy_b, done_b, id_ok_b, ts_ok_b, pass_b, timeout_err_b;
  logic [31:0] captured_id_b, captured_ts_b;

  // slave configuration
  logic [3:0]  wait_cfg = 4'd0;
  logic        lat1 = 1'b1;
  logic        resp_id = 1'b1;
  logic        resp_ts = 1'b1;
  logic        stale_rdv = 1'b0;
  logic [31:0] id_val = 32'h0;
  logic [31:0] ts_val = EXP_TS;

  // slave state and monitor
  logic [3:0]  stall_cnt = 4'd0;
  logic        pend = 1'b0;
  logic [31:0] pend_addr = 32'h0;
  logic        resp_now;
  logic [31:0] src_addr;
  int          acc_total = 0;
  int          stall_viol = 0;
  logic        prev_stalled = 1'b0;
  logic [31:0] prev_addr = 32'h0;
  logic [31:0] acc_addr [64];

  int n_chk = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  sysid_checker #(
    .ADDR_W(32), .BASE_ADDR(32'h0), .EXPECTED_ID(32'h0), .EXPECTED_TS(EXP_TS),
    .CHECK_TS(1'b1), .TIMEOUT_CYCLES(16), .MAX_RETRIES(2)
  ) u_dut (
    .clock(clock), .reset_n(reset_n), .start(start),
    .avm_address(avm_address), .avm_read(avm_read),
    .avm_waitrequest(waitreq), .avm_readdatavalid(rdv), .avm_readdata(rdata),
    .busy(busy), .done(done), .id_ok(id_ok), .ts_ok(ts_ok), .pass(pass),
    .timeout_err(timeout_err), .captured_id(captured_id), .captured_ts(captured_ts)
  );

  sysid_checker #(
    .ADDR_W(32), .BASE_ADDR(32'h0), .EXPECTED_ID(32'h0), .EXPECTED_TS(EXP_TS),
    .CHECK_TS(1'b0), .TIMEOUT_CYCLES(16), .MAX_RETRIES(2)
  ) u_dut_nots (
    .clock(clock), .reset_n(reset_n), .start(start),
    .avm_address(avm_address_b), .avm_read(avm_read_b),
    .avm_waitrequest(waitreq), .avm_readdatavalid(rdv), .avm_readdata(rdata),
    .busy(busy_b), .done(done_b), .id_ok(id_ok_b), .ts_ok(ts_ok_b), .pass(pass_b),
    .timeout_err(timeout_err_b), .captured_id(captured_id_b), .captured_ts(captured_ts_b)
  );

  assign waitreq  = avm_read && (stall_cnt < wait_cfg);
  assign resp_now = (avm_address == 32'h0) ? resp_id : resp_ts;
  assign src_addr = pend ? pend_addr : avm_address;
  assign rdv      = stale_rdv || pend || (!lat1 && avm_read && !waitreq && resp_now);
  assign rdata    = stale_rdv ? 32'hDEAD_BEEF : ((src_addr == 32'h0) ? id_val : ts_val);

  always @(posedge clock) begin
    if (avm_read && waitreq) stall_cnt <= stall_cnt + 4'd1;
    else stall_cnt <= 4'd0;
    pend      <= lat1 && avm_read && !waitreq && resp_now;
    pend_addr <= avm_address;
    if (avm_read && !waitreq) begin
      acc_addr[6'(acc_total)] <= avm_address;
      acc_total <= acc_total + 1;
    end
    if (prev_stalled && (!avm_read || (avm_address != prev_addr))) stall_viol <= stall_viol + 1;
    prev_stalled <= avm_read && waitreq;
    prev_addr    <= avm_address;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input int budget, output int cycles);
    cycles = 0;
    while ((done !== 1'b1) && (cycles < budget)) begin
      @(negedge clock);
      cycles++;
    end
    chk("done_reached", 32'(done), 32'd1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cyc;
    int base;
    int sv_base;
    int n;

    // reset state
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    chk("rst_ctrl", 32'({busy, done, id_ok, ts_ok, pass, timeout_err, avm_read}), 32'd0);
    chk("rst_addr", avm_address, 32'h0);
    chk("rst_cap", captured_id | captured_ts, 32'h0);

    // automatic check after reset, zero wait, one-cycle data latency
    base = acc_total;
    reset_n = 1'b1;
    wait_done(20, cyc);
    chk("boot_latency_le8", 32'(cyc <= 8), 32'd1);
    chk("boot_pass", 32'(pass), 32'd1);
    chk("boot_id_ok", 32'(id_ok), 32'd1);
    chk("boot_ts_ok", 32'(ts_ok), 32'd1);
    chk("boot_busy", 32'(busy), 32'd0);
    chk("boot_nreads", 32'(acc_total - base), 32'd2);
    chk("boot_addr0", acc_addr[6'(base)], 32'h0);
    chk("boot_addr1", acc_addr[6'(base + 1)], 32'h4);
    chk("boot_cap_ts", captured_ts, EXP_TS);

    // restart with 5-cycle waitrequest; extra start while busy is ignored
    wait_cfg = 4'd5;
    base = acc_total;
    sv_base = stall_viol;
    pulse_start();
    chk("start_clr_done", 32'(done), 32'd0);
    chk("start_busy", 32'(busy), 32'd1);
    repeat (3) @(negedge clock);
    pulse_start();
    wait_done(60, cyc);
    chk("stall_pass", 32'(pass), 32'd1);
    chk("stall_nreads", 32'(acc_total - base), 32'd2);
    chk("stall_stable", 32'(stall_viol - sv_base), 32'd0);
    chk("stall_addr1", acc_addr[6'(base + 1)], 32'h4);
    @(negedge clock);
    chk("busy_start_ignored", 32'(acc_total - base), 32'd2);

    // wrong ID
    wait_cfg = 4'd0;
    id_val = 32'h1;
    pulse_start();
    wait_done(20, cyc);
    chk("badid_id_ok", 32'(id_ok), 32'd0);
    chk("badid_pass", 32'(pass), 32'd0);
    chk("badid_cap", captured_id, 32'h1);
    chk("badid_ts_ok", 32'(ts_ok), 32'd1);
    chk("badid_pass_nots", 32'(pass_b), 32'd0);

    // wrong timestamp only
    id_val = 32'h0;
    ts_val = EXP_TS ^ 32'h1;
    pulse_start();
    wait_done(20, cyc);
    chk("badts_pass", 32'(pass), 32'd0);
    chk("badts_ts_ok", 32'(ts_ok), 32'd0);
    chk("badts_id_ok", 32'(id_ok), 32'd1);
    chk("badts_cap", captured_ts, EXP_TS ^ 32'h1);
    chk("badts_pass_nots", 32'(pass_b), 32'd1);
    chk("badts_ts_ok_nots", 32'(ts_ok_b), 32'd0);

    // readdatavalid in the accept cycle
    ts_val = EXP_TS;
    lat1 = 1'b0;
    base = acc_total;
    pulse_start();
    wait_done(20, cyc);
    chk("same_cycle_pass", 32'(pass), 32'd1);
    chk("same_cycle_latency", 32'(cyc), 32'd2);
    chk("same_cycle_nreads", 32'(acc_total - base), 32'd2);

    // no readdatavalid at all: three attempts then timeout
    lat1 = 1'b1;
    resp_id = 1'b0;
    resp_ts = 1'b0;
    reset_n = 1'b0;
    @(negedge clock);
    base = acc_total;
    reset_n = 1'b1;
    wait_done(80, cyc);
    chk("tmo_err", 32'(timeout_err), 32'd1);
    chk("tmo_pass", 32'(pass), 32'd0);
    chk("tmo_id_ok", 32'(id_ok), 32'd0);
    chk("tmo_busy", 32'(busy), 32'd0);
    chk("tmo_window", 32'((cyc >= 45) && (cyc <= 51)), 32'd1);
    chk("tmo_nreads", 32'(acc_total - base), 32'd3);
    chk("tmo_addrs", acc_addr[6'(base)] | acc_addr[6'(base + 1)] | acc_addr[6'(base + 2)], 32'h0);

    // reset while waiting for the timestamp, stale readdatavalid after release
    resp_id = 1'b1;
    id_val = 32'h1;
    pulse_start();
    chk("start_clr_tmo", 32'(timeout_err), 32'd0);
    n = 0;
    while (!((avm_address == 32'h4) && !avm_read && busy) && (n < 50)) begin
      @(negedge clock);
      n++;
    end
    chk("reach_wait_ts", 32'((avm_address == 32'h4) && !avm_read), 32'd1);
    chk("pre_rst_cap_id", captured_id, 32'h1);
    reset_n = 1'b0;
    #1;
    chk("midrst_ctrl", 32'({busy, done, id_ok, ts_ok, pass, timeout_err, avm_read}), 32'd0);
    chk("midrst_addr", avm_address, 32'h0);
    chk("midrst_cap_id", captured_id, 32'h0);
    @(negedge clock);
    id_val = 32'h0;
    resp_ts = 1'b1;
    base = acc_total;
    reset_n = 1'b1;
    stale_rdv = 1'b1;
    @(negedge clock);
    stale_rdv = 1'b0;
    chk("stale_cap", captured_id | captured_ts, 32'h0);
    wait_done(20, cyc);
    chk("rerun_pass", 32'(pass), 32'd1);
    chk("rerun_addr0", acc_addr[6'(base)], 32'h0);
    chk("rerun_cap_ts", captured_ts, EXP_TS);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
